// File: rtl/adsr_pkg.sv
// adsr_pkg: shared types and helpers for the ADSR envelope / VCA voice stage.
//   adsr_state_t : envelope FSM state encoding
//   GAIN_WIDTH   : width of the VCA gain (top bits of the envelope)
//   sat_add      : add with saturation at 2^w-1 (no wrap)
//   sat_sub      : subtract clamped at a floor (no underflow)
// The helpers work on 64-bit containers with the live width passed in, so
// any ENV_WIDTH up to 63 can use them.
package adsr_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } adsr_state_t;

  localparam int GAIN_WIDTH = 16;

  // a + b, saturating at 2^w-1. One extra bit of headroom catches the carry.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] s;
    logic [63:0] mx;
    mx = (64'd1 << w) - 64'd1;
    s  = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, mx}) sat_add = mx;
    else                 sat_add = s[63:0];
  endfunction

  // a - b, clamped to floor when the true result would be <= floor.
  // b >= a is checked first so the difference is never formed negative.
  function automatic logic [63:0] sat_sub(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic [63:0] floor);
    if (b >= a)               sat_sub = floor;
    else if (a - b <= floor)  sat_sub = floor;
    else                      sat_sub = a - b;
  endfunction

endpackage

// File: rtl/adsr_envelope_vca_vca_mult.sv
// adsr_envelope_vca_vca_mult: signed sample x unsigned gain VCA.
//   i_sample_en  : strobe; captures i_sample_in
//   i_sample_in  : signed 16-bit sample
//   i_gain       : unsigned gain, read the cycle after the strobe so it
//                  reflects the envelope update made on the strobe edge
//   o_sample_out : (sample * gain) >>> 16, held between updates
//   o_out_valid  : one-clk pulse when o_sample_out updates
module adsr_envelope_vca_vca_mult
  import adsr_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_active_high,
  input  logic                  i_sample_en,
  input  logic [DATA_WIDTH-1:0] i_sample_in,
  input  logic [GAIN_WIDTH-1:0] i_gain,
  output logic [DATA_WIDTH-1:0] o_sample_out,
  output logic                  o_out_valid
);

  localparam int STAGES = 2;
  localparam int PW     = DATA_WIDTH + GAIN_WIDTH + 1;

  logic signed [DATA_WIDTH-1:0] r_s;
  logic [STAGES:1]              r_vld_pipe;
  logic signed [PW-1:0]         w_prod;

  // Gain is zero-extended to keep it positive in the signed multiply.
  assign w_prod = PW'(r_s) * PW'($signed({1'b0, i_gain}));

  always_ff @(posedge clk or posedge rst_active_high) begin
    if (rst_active_high) begin
      r_s          <= '0;
      r_vld_pipe   <= '0;
      o_sample_out <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], i_sample_en};
      if (i_sample_en) r_s <= $signed(i_sample_in);
      // Arithmetic shift floors; keep product bits [31:16].
      if (r_vld_pipe[1]) o_sample_out <= DATA_WIDTH'(w_prod >>> GAIN_WIDTH);
    end
  end

  assign o_out_valid = r_vld_pipe[STAGES];

endmodule

// File: rtl/adsr_envelope_vca.sv
// adsr_envelope_vca: per-voice ADSR envelope generator feeding a VCA.
//   clk, rst_active_high : clock, async active-high reset
//   sample_en            : audio-rate strobe; all envelope state moves only here
//   gate                 : note on/off level, edge-detected per strobe
//   attack/decay/release_rate : per-strobe step (0 = jump immediately)
//   sustain_level        : sustain gain, tracked live in SUSTAIN
//   sample_in/sample_out : signed oscillator sample in, shaped sample out
//   out_valid            : pulse when sample_out updates
//   env_level            : top 16 bits of the envelope
//   active               : envelope not IDLE
module adsr_envelope_vca
  import adsr_pkg::*;
#(
  parameter int ENV_WIDTH  = 24,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_active_high,
  input  logic                  sample_en,
  input  logic                  gate,
  input  logic [ENV_WIDTH-1:0]  attack_rate,
  input  logic [ENV_WIDTH-1:0]  decay_rate,
  input  logic [15:0]           sustain_level,
  input  logic [ENV_WIDTH-1:0]  release_rate,
  input  logic [DATA_WIDTH-1:0] sample_in,
  output logic [DATA_WIDTH-1:0] sample_out,
  output logic                  out_valid,
  output logic [15:0]           env_level,
  output logic                  active
);

  localparam int unsigned EW      = ENV_WIDTH;
  localparam logic [ENV_WIDTH-1:0] ENV_MAX = '1;

  adsr_state_t          r_state, w_state_nxt;
  logic [ENV_WIDTH-1:0] r_env, w_env_nxt;
  logic                 r_gate_prev;

  logic [ENV_WIDTH-1:0] w_target, w_att, w_dec, w_rel;
  logic                 w_rise, w_fall;

  assign w_target = {sustain_level, {(ENV_WIDTH-GAIN_WIDTH){1'b0}}};
  assign w_att    = ENV_WIDTH'(sat_add(64'(r_env), 64'(attack_rate), EW));
  assign w_dec    = ENV_WIDTH'(sat_sub(64'(r_env), 64'(decay_rate), 64'(w_target)));
  assign w_rel    = ENV_WIDTH'(sat_sub(64'(r_env), 64'(release_rate), 64'd0));
  assign w_rise   = gate & ~r_gate_prev;
  assign w_fall   = ~gate & r_gate_prev;

  always_ff @(posedge clk or posedge rst_active_high) begin
    if (rst_active_high) begin
      r_state     <= IDLE;
      r_env       <= '0;
      r_gate_prev <= 1'b0;
    end else if (sample_en) begin
      r_state     <= w_state_nxt;
      r_env       <= w_env_nxt;
      r_gate_prev <= gate;
    end
  end

  // Gate edges take priority and leave env untouched, so a retrigger
  // ramps from the current level instead of clicking back to zero.
  always_comb begin
    w_state_nxt = r_state;
    w_env_nxt   = r_env;
    if (w_rise) begin
      w_state_nxt = ATTACK;
    end else if (w_fall && (r_state == ATTACK || r_state == DECAY ||
                            r_state == SUSTAIN)) begin
      w_state_nxt = RELEASE;
    end else begin
      case (r_state)
        IDLE: w_env_nxt = '0;
        ATTACK: begin
          if (attack_rate == '0 || w_att == ENV_MAX) begin
            w_env_nxt   = ENV_MAX;
            w_state_nxt = DECAY;
          end else begin
            w_env_nxt = w_att;
          end
        end
        DECAY: begin
          // w_dec is already clamped, so reaching target means <= target.
          if (decay_rate == '0 || w_dec == w_target) begin
            w_env_nxt   = w_target;
            w_state_nxt = SUSTAIN;
          end else begin
            w_env_nxt = w_dec;
          end
        end
        SUSTAIN: w_env_nxt = w_target;
        RELEASE: begin
          if (release_rate == '0 || w_rel == '0) begin
            w_env_nxt   = '0;
            w_state_nxt = IDLE;
          end else begin
            w_env_nxt = w_rel;
          end
        end
        default: begin
          w_env_nxt   = '0;
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  assign env_level = r_env[ENV_WIDTH-1 -: GAIN_WIDTH];
  assign active    = (r_state != IDLE);

  adsr_envelope_vca_vca_mult #(.DATA_WIDTH(DATA_WIDTH)) u_vca (
    .clk             (clk),
    .rst_active_high (rst_active_high),
    .i_sample_en     (sample_en),
    .i_sample_in     (sample_in),
    .i_gain          (env_level),
    .o_sample_out    (sample_out),
    .o_out_valid     (out_valid)
  );

endmodule

// File: tb/tb_adsr_envelope_vca.sv
module tb_adsr_envelope_vca;

  logic        clk = 1'b0;
  logic        rst_active_high = 1'b1;
  logic        sample_en = 1'b0;
  logic        gate = 1'b0;
  logic [23:0] attack_rate = '0;
  logic [23:0] decay_rate = '0;
  logic [15:0] sustain_level = '0;
  logic [23:0] release_rate = '0;
  logic [15:0] sample_in = '0;
  logic [15:0] sample_out;
  logic        out_valid;
  logic [15:0] env_level;
  logic        active;

  int total = 0;
  int bad = 0;

  adsr_envelope_vca dut (
    .clk             (clk),
    .rst_active_high (rst_active_high),
    .sample_en       (sample_en),
    .gate            (gate),
    .attack_rate     (attack_rate),
    .decay_rate      (decay_rate),
    .sustain_level   (sustain_level),
    .release_rate    (release_rate),
    .sample_in       (sample_in),
    .sample_out      (sample_out),
    .out_valid       (out_valid),
    .env_level       (env_level),
    .active          (active)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  // One strobe: raised at a negedge, dropped at the next; returns at that
  // negedge so the tick edge's results are visible.
  task automatic tick();
    @(negedge clk); sample_en = 1'b1;
    @(negedge clk); sample_en = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (env_level !== 16'h0) begin bad++; $display("FAIL reset_env got=%h exp=0", env_level); end
    total++; if (active !== 1'b0) begin bad++; $display("FAIL reset_active got=%b exp=0", active); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (sample_out !== 16'h0) begin bad++; $display("FAIL reset_out got=%h exp=0", sample_out); end
    rst_active_high = 1'b0;
  endtask

  task automatic test_reset_mid_attack();
    attack_rate = 24'h100000; sample_in = 16'h4000; gate = 1'b1;
    tick();
    repeat (4) tick();
    total++; if (env_level !== 16'h4000) begin bad++; $display("FAIL midatk_env got=%h exp=4000", env_level); end
    @(posedge clk); #1;
    total++; if (sample_out !== 16'h1000) begin bad++; $display("FAIL midatk_out got=%h exp=1000", sample_out); end
    #2 rst_active_high = 1'b1;
    #1;
    total++; if (env_level !== 16'h0) begin bad++; $display("FAIL rstmid_env got=%h exp=0", env_level); end
    total++; if (active !== 1'b0) begin bad++; $display("FAIL rstmid_active got=%b exp=0", active); end
    total++; if (sample_out !== 16'h0) begin bad++; $display("FAIL rstmid_out got=%h exp=0", sample_out); end
    @(negedge clk); gate = 1'b0; rst_active_high = 1'b0;
    tick();
    total++; if (active !== 1'b0) begin bad++; $display("FAIL idle_after_rst got=%b exp=0", active); end
  endtask

  task automatic test_attack();
    attack_rate = 24'h100000; gate = 1'b1; sample_in = 16'h0;
    tick();
    total++; if (active !== 1'b1 || env_level !== 16'h0) begin bad++; $display("FAIL atk_edge act=%b env=%h exp act=1 env=0", active, env_level); end
    repeat (15) tick();
    total++; if (env_level !== 16'hF000) begin bad++; $display("FAIL atk_15 got=%h exp=f000", env_level); end
    tick();
    total++; if (env_level !== 16'hFFFF) begin bad++; $display("FAIL atk_sat got=%h exp=ffff", env_level); end
  endtask

  task automatic test_decay_sustain();
    decay_rate = 24'h080000; sustain_level = 16'h8000;
    repeat (15) tick();
    total++; if (env_level !== 16'h87FF) begin bad++; $display("FAIL dec_15 got=%h exp=87ff", env_level); end
    tick();
    total++; if (env_level !== 16'h8000) begin bad++; $display("FAIL dec_clamp got=%h exp=8000", env_level); end
    tick();
    total++; if (env_level !== 16'h8000) begin bad++; $display("FAIL sus_hold got=%h exp=8000", env_level); end
    sustain_level = 16'h4000;
    tick();
    total++; if (env_level !== 16'h4000) begin bad++; $display("FAIL sus_track got=%h exp=4000", env_level); end
    sustain_level = 16'h8000;
    tick();
    total++; if (env_level !== 16'h8000) begin bad++; $display("FAIL sus_back got=%h exp=8000", env_level); end
  endtask

  task automatic test_vca();
    sample_in = 16'h4000;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL vca_early got=%b exp=0", out_valid); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1 || sample_out !== 16'h2000) begin bad++; $display("FAIL vca_half v=%b out=%h exp v=1 out=2000", out_valid, sample_out); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || sample_out !== 16'h2000) begin bad++; $display("FAIL vca_hold v=%b out=%h exp v=0 out=2000", out_valid, sample_out); end
  endtask

  task automatic test_release();
    release_rate = 24'h200000; gate = 1'b0;
    tick();
    total++; if (active !== 1'b1 || env_level !== 16'h8000) begin bad++; $display("FAIL rel_edge act=%b env=%h exp act=1 env=8000", active, env_level); end
    repeat (3) tick();
    total++; if (active !== 1'b1 || env_level !== 16'h2000) begin bad++; $display("FAIL rel_3 act=%b env=%h exp act=1 env=2000", active, env_level); end
    tick();
    total++; if (active !== 1'b0 || env_level !== 16'h0) begin bad++; $display("FAIL rel_idle act=%b env=%h exp act=0 env=0", active, env_level); end
  endtask

  task automatic test_edge_cases();
    gate = 1'b1; attack_rate = 24'h0; decay_rate = 24'h0;
    tick();
    tick();
    total++; if (env_level !== 16'hFFFF) begin bad++; $display("FAIL atk_zero got=%h exp=ffff", env_level); end
    tick();
    total++; if (env_level !== 16'h8000) begin bad++; $display("FAIL dec_zero got=%h exp=8000", env_level); end
    gate = 1'b0;
    tick();
    tick();
    total++; if (env_level !== 16'h6000) begin bad++; $display("FAIL rel_step got=%h exp=6000", env_level); end
    gate = 1'b1; attack_rate = 24'h100000;
    tick();
    total++; if (env_level !== 16'h6000 || active !== 1'b1) begin bad++; $display("FAIL retrig_edge env=%h act=%b exp env=6000 act=1", env_level, active); end
    tick();
    total++; if (env_level !== 16'h7000) begin bad++; $display("FAIL retrig_ramp got=%h exp=7000", env_level); end
    attack_rate = 24'h0; sample_in = 16'h8000;
    tick();
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1 || sample_out !== 16'h8000) begin bad++; $display("FAIL vca_fullneg v=%b out=%h exp v=1 out=8000", out_valid, sample_out); end
  endtask

  task automatic test_back_to_back();
    decay_rate = 24'h080000; sustain_level = 16'h8000;
    @(negedge clk); sample_en = 1'b1; sample_in = 16'h4000;
    @(negedge clk); sample_in = 16'h2000;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1 || sample_out !== 16'h3DFF) begin bad++; $display("FAIL b2b_first v=%b out=%h exp v=1 out=3dff", out_valid, sample_out); end
    @(negedge clk); sample_en = 1'b0;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1 || sample_out !== 16'h1DFF) begin bad++; $display("FAIL b2b_second v=%b out=%h exp v=1 out=1dff", out_valid, sample_out); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b exp=0", out_valid); end
    total++; if (env_level !== 16'hEFFF) begin bad++; $display("FAIL b2b_env got=%h exp=efff", env_level); end
  endtask

  task automatic test_hold();
    int vcount;
    vcount = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      gate = i[0];
      sample_in = 16'(i * 517);
      if (out_valid) vcount++;
    end
    gate = 1'b1;
    total++; if (vcount !== 0) begin bad++; $display("FAIL hold_valid got=%0d exp=0", vcount); end
    total++; if (env_level !== 16'hEFFF || active !== 1'b1) begin bad++; $display("FAIL hold_state env=%h act=%b exp env=efff act=1", env_level, active); end
    tick();
    total++; if (env_level !== 16'hE7FF) begin bad++; $display("FAIL hold_resume got=%h exp=e7ff", env_level); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_attack();
    test_attack();
    test_decay_sustain();
    test_vca();
    test_release();
    test_edge_cases();
    test_back_to_back();
    test_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
